// File: rtl/point_raster_sink.sv
// point_raster_sink
// Consumer end of a generator coordinate stream. Signed (x, y) points are
// accepted over a valid/ready handshake and plotted into a 1-bit on-chip
// framebuffer. Points outside the framebuffer are clipped and counted. Once
// the producer signals completion, the framebuffer is streamed out one row
// per handshake.
//
// Ports:
//   i_clock, i_reset      clock, asynchronous active-high reset
//   i_start               start a run (honoured in IDLE and DONE)
//   i_in0 / i_in1         signed point x / y
//   i_in_valid/o_in_ready point handshake (ready only in COLLECT)
//   i_in_done             producer finished (honoured in COLLECT)
//   o_row_data            framebuffer row o_row_index, bit x = pixel x
//   o_row_index           row being presented
//   o_row_valid/i_row_ready  row handshake (valid only in DUMP)
//   o_plotted / o_clipped saturating counts of in-bounds / clipped points
//   o_done                readout complete, held until the next start
//
// Build option: define POINT_RASTER_SINK_XOR_EN to make each in-bounds point
// toggle its pixel instead of setting it.

module point_raster_sink #(
  parameter int WIDTH   = 32,
  parameter int HEIGHT  = 32,
  parameter int COORD_W = 32
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_start,
  input  logic signed [COORD_W-1:0]  i_in0,
  input  logic signed [COORD_W-1:0]  i_in1,
  input  logic                       i_in_valid,
  output logic                       o_in_ready,
  input  logic                       i_in_done,
  output logic [WIDTH-1:0]           o_row_data,
  output logic [$clog2(HEIGHT)-1:0]  o_row_index,
  output logic                       o_row_valid,
  input  logic                       i_row_ready,
  output logic [15:0]                o_plotted,
  output logic [15:0]                o_clipped,
  output logic                       o_done
);

  localparam int XW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam logic signed [COORD_W-1:0] LP_W = COORD_W'(WIDTH);
  localparam logic signed [COORD_W-1:0] LP_H = COORD_W'(HEIGHT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_COLLECT,
    S_DUMP,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [WIDTH-1:0] r_fb [HEIGHT];
  logic [RW:0]      r_clr_cnt;
  logic [RW-1:0]    r_row_index;
  logic [15:0]      r_plotted;
  logic [15:0]      r_clipped;
  logic             r_done;

  logic             w_accept;
  logic             w_in_bounds;
  logic [XW-1:0]    w_x_idx;
  logic [RW-1:0]    w_y_idx;
  logic [WIDTH-1:0] w_mask;
  logic             w_last_row;

  // Sign bit clear plus signed upper-bound compare at full coordinate width.
  assign w_in_bounds = !i_in0[COORD_W-1] && (i_in0 < LP_W) &&
                       !i_in1[COORD_W-1] && (i_in1 < LP_H);
  assign w_x_idx     = i_in0[XW-1:0];
  assign w_y_idx     = i_in1[RW-1:0];
  assign w_mask      = {{(WIDTH-1){1'b0}}, 1'b1} << w_x_idx;
  assign w_accept    = i_in_valid && (r_state == S_COLLECT);
  assign w_last_row  = (r_row_index == RW'(HEIGHT - 1));

  // Handshake outputs are pure decodes of the state register.
  assign o_in_ready  = (r_state == S_COLLECT);
  assign o_row_valid = (r_state == S_DUMP);
  assign o_row_data  = (r_state == S_DUMP) ? r_fb[r_row_index] : '0;
  assign o_row_index = r_row_index;
  assign o_plotted   = r_plotted;
  assign o_clipped   = r_clipped;
  assign o_done      = r_done;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (i_start) w_state_next = S_CLEAR;
      // HEIGHT clearing cycles plus one terminal cycle, so COLLECT opens
      // HEIGHT+1 cycles after the start edge.
      S_CLEAR:   if (r_clr_cnt == (RW+1)'(HEIGHT)) w_state_next = S_COLLECT;
      S_COLLECT: if (i_in_done) w_state_next = S_DUMP;
      S_DUMP:    if (i_row_ready && w_last_row) w_state_next = S_DONE;
      S_DONE:    if (i_start) w_state_next = S_CLEAR;
      default:   w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < HEIGHT; i++) r_fb[i] <= '0;
      r_clr_cnt   <= '0;
      r_row_index <= '0;
      r_plotted   <= '0;
      r_clipped   <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= (w_state_next == S_DONE);
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_clr_cnt   <= '0;
            r_row_index <= '0;
            r_plotted   <= '0;
            r_clipped   <= '0;
          end
        end
        S_CLEAR: begin
          if (r_clr_cnt < (RW+1)'(HEIGHT)) begin
            r_fb[r_clr_cnt[RW-1:0]] <= '0;
            r_clr_cnt <= r_clr_cnt + 1'b1;
          end
        end
        S_COLLECT: begin
          // A point arriving with i_in_done is still plotted before DUMP.
          if (w_accept) begin
            if (w_in_bounds) begin
`ifdef POINT_RASTER_SINK_XOR_EN
              r_fb[w_y_idx] <= r_fb[w_y_idx] ^ w_mask;
`else
              r_fb[w_y_idx] <= r_fb[w_y_idx] | w_mask;
`endif
              if (r_plotted != 16'hFFFF) r_plotted <= r_plotted + 16'd1;
            end else begin
              if (r_clipped != 16'hFFFF) r_clipped <= r_clipped + 16'd1;
            end
          end
          if (i_in_done) r_row_index <= '0;
        end
        S_DUMP: begin
          if (i_row_ready) begin
            if (w_last_row) r_row_index <= '0;
            else            r_row_index <= r_row_index + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_point_raster_sink.sv
module tb_point_raster_sink;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               start = 1'b0;
  logic signed [31:0] in0 = '0;
  logic signed [31:0] in1 = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic               in_done = 1'b0;
  logic [31:0]        row_data;
  logic [4:0]         row_index;
  logic               row_valid;
  logic               row_ready = 1'b0;
  logic [15:0]        plotted;
  logic [15:0]        clipped;
  logic               done;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_rows [32];

  point_raster_sink #(.WIDTH(32), .HEIGHT(32), .COORD_W(32)) dut (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_start     (start),
    .i_in0       (in0),
    .i_in1       (in1),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_done   (in_done),
    .o_row_data  (row_data),
    .o_row_index (row_index),
    .o_row_valid (row_valid),
    .i_row_ready (row_ready),
    .o_plotted   (plotted),
    .o_clipped   (clipped),
    .o_done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_checks++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 32; i++) exp_rows[i] = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Pulses start and returns the number of edges after the sampling edge
  // until in_ready is seen high.
  task automatic start_run(output int lat);
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    while (!in_ready && lat < 100) begin
      tick();
      lat++;
    end
    $display("start: in_ready after %0d cycles", lat);
  endtask

  task automatic send_point(input int x, input int y, input logic with_done);
    in0 = x;
    in1 = y;
    in_valid = 1'b1;
    in_done = with_done;
    tick();
    in_valid = 1'b0;
    in_done = 1'b0;
    $display("point (%0d,%0d) done=%0b", x, y, with_done);
  endtask

  task automatic finish_points();
    in_done = 1'b1;
    tick();
    in_done = 1'b0;
    $display("in_done");
  endtask

  // Reads all 32 rows against exp_rows; stalls 3 cycles at stall_row.
  task automatic readout(input string tag, input int stall_row);
    row_ready = 1'b1;
    for (int r = 0; r < 32; r++) begin
      if (r == stall_row) begin
        row_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          tick();
          check({tag, "_stall_idx"}, 64'(row_index), 64'(r));
          check({tag, "_stall_data"}, 64'(row_data), 64'(exp_rows[r]));
        end
        row_ready = 1'b1;
      end
      check({tag, "_row_valid"}, 64'(row_valid), 64'd1);
      check({tag, "_row_index"}, 64'(row_index), 64'(r));
      check($sformatf("%s_row%0d", tag, r), 64'(row_data), 64'(exp_rows[r]));
      $display("%s row %0d data 0x%08h", tag, r, row_data);
      tick();
    end
    row_ready = 1'b0;
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_row_valid_off"}, 64'(row_valid), 64'd0);
  endtask

  initial begin
    int lat;
    do_reset();

    // Reset state
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_row_valid", 64'(row_valid), 64'd0);
    check("rst_row_index", 64'(row_index), 64'd0);
    check("rst_row_data", 64'(row_data), 64'd0);
    check("rst_plotted", 64'(plotted), 64'd0);
    check("rst_clipped", 64'(clipped), 64'd0);
    check("rst_done", 64'(done), 64'd0);

    // Single points, with start latency
    start_run(lat);
    check("start_latency", 64'(lat), 64'd33);
    send_point(0, 0, 1'b0);
    send_point(5, 2, 1'b0);
    send_point(31, 31, 1'b0);
    check("single_done_early", 64'(done), 64'd0);
    finish_points();
    clear_exp();
    exp_rows[0]  = 32'h0000_0001;
    exp_rows[2]  = 32'h0000_0020;
    exp_rows[31] = 32'h8000_0000;
    readout("single", -1);
    check("single_plotted", 64'(plotted), 64'd3);
    check("single_clipped", 64'(clipped), 64'd0);

    // Clipping (start from DONE)
    start_run(lat);
    check("clip_start_latency", 64'(lat), 64'd33);
    check("clip_plotted_zeroed", 64'(plotted), 64'd0);
    check("clip_done_cleared", 64'(done), 64'd0);
    send_point(-1, 0, 1'b0);
    send_point(32, 5, 1'b0);
    send_point(3, 32, 1'b0);
    send_point(0, -7, 1'b0);
    finish_points();
    clear_exp();
    readout("clip", -1);
    check("clip_clipped", 64'(clipped), 64'd4);
    check("clip_plotted", 64'(plotted), 64'd0);

    // Rectangle border, origin (23,17), 7 wide, 5 tall, no duplicates
    start_run(lat);
    for (int x = 23; x <= 29; x++) send_point(x, 17, 1'b0);
    for (int y = 18; y <= 20; y++) begin
      send_point(23, y, 1'b0);
      send_point(29, y, 1'b0);
    end
    for (int x = 23; x <= 29; x++) send_point(x, 21, 1'b0);
    finish_points();
    clear_exp();
    exp_rows[17] = 32'h3F80_0000;
    exp_rows[21] = 32'h3F80_0000;
    exp_rows[18] = 32'h2080_0000;
    exp_rows[19] = 32'h2080_0000;
    exp_rows[20] = 32'h2080_0000;
    readout("rect", -1);
    check("rect_plotted", 64'(plotted), 64'd20);

    // Backpressure at row 4 and duplicate point
    start_run(lat);
    send_point(10, 4, 1'b0);
    send_point(7, 7, 1'b0);
    send_point(7, 7, 1'b0);
    finish_points();
    clear_exp();
    exp_rows[4] = 32'h0000_0400;
`ifdef POINT_RASTER_SINK_XOR_EN
    exp_rows[7] = 32'h0000_0000;
`else
    exp_rows[7] = 32'h0000_0080;
`endif
    readout("dup", 4);
    check("dup_plotted", 64'(plotted), 64'd3);

    // Point accepted in the same cycle as in_done
    start_run(lat);
    send_point(1, 1, 1'b1);
    check("simul_row_valid", 64'(row_valid), 64'd1);
    clear_exp();
    exp_rows[1] = 32'h0000_0002;
    readout("simul", -1);
    check("simul_plotted", 64'(plotted), 64'd1);

    // Reset in the middle of COLLECT
    start_run(lat);
    send_point(2, 3, 1'b0);
    send_point(40, 3, 1'b0);
    check("mid_plotted_pre", 64'(plotted), 64'd1);
    check("mid_clipped_pre", 64'(clipped), 64'd1);
    do_reset();
    check("mid_in_ready", 64'(in_ready), 64'd0);
    check("mid_plotted", 64'(plotted), 64'd0);
    check("mid_clipped", 64'(clipped), 64'd0);
    check("mid_done", 64'(done), 64'd0);
    check("mid_row_valid", 64'(row_valid), 64'd0);
    check("mid_row_data", 64'(row_data), 64'd0);

    // Fresh run after reset
    start_run(lat);
    check("fresh_start_latency", 64'(lat), 64'd33);
    send_point(9, 30, 1'b0);
    finish_points();
    clear_exp();
    exp_rows[30] = 32'h0000_0200;
    readout("fresh", -1);
    check("fresh_plotted", 64'(plotted), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
